// File: rtl/twiddle_mul_if.sv
// Request/result bundle between the twiddle multiplier and its neighbours.
// The master drives the operands and mul_en; the slave (twiddle_mul) returns results.
interface twiddle_mul_if #(
   parameter int N = 8
);
   logic                mul_en;
   logic signed [N-1:0] Rea;
   logic signed [N-1:0] Ima;
   logic signed [N-1:0] Reb;
   logic signed [N-1:0] Imb;
   logic signed [N-1:0] Wr;
   logic signed [N-1:0] Wi;
   logic signed [N-1:0] RE;
   logic signed [N-1:0] IM;
   logic signed [N-1:0] Rea_q;
   logic signed [N-1:0] Ima_q;
   logic                cal_en;
   logic                busy;

   modport master (
      output mul_en, Rea, Ima, Reb, Imb, Wr, Wi,
      input  RE, IM, Rea_q, Ima_q, cal_en, busy
   );

   modport slave (
      input  mul_en, Rea, Ima, Reb, Imb, Wr, Wi,
      output RE, IM, Rea_q, Ima_q, cal_en, busy
   );
endinterface

// File: rtl/twiddle_mul.sv
// Radix-2 butterfly twiddle multiplier: b*W over four cycles on one shared signed multiplier.
// Define TWIDDLE_SAT_EN to saturate scaled results; otherwise they wrap to N bits.
//
// state | meaning
// IDLE  | waiting for mul_en; the cal_en pulse is visible here
// M0    | acc_r = Reb*Wr
// M1    | acc_r -= Imb*Wi
// M2    | RE = scale(acc_r); acc_i = Reb*Wi
// M3    | IM = scale(acc_i + Imb*Wr); forward a operand; raise cal_en
module twiddle_mul #(
   parameter int N    = 8,
   parameter int FRAC = N - 1
) (
   input  logic           Clock,
   input  logic           nRst,
   twiddle_mul_if.slave   bus
);

   localparam int PW = 2 * N;
   localparam int AW = 2 * N + 1;
   localparam logic signed [AW-1:0] RND   = AW'(1 << (FRAC - 1));
   localparam logic signed [AW-1:0] MAX_V = AW'((1 << (N - 1)) - 1);
   localparam logic signed [AW-1:0] MIN_V = AW'(-(1 << (N - 1)));

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      M0   = 3'd1,
      M1   = 3'd2,
      M2   = 3'd3,
      M3   = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic signed [N-1:0]  rea_q, rea_d, ima_q, ima_d;
   logic signed [N-1:0]  reb_q, reb_d, imb_q, imb_d;
   logic signed [N-1:0]  wr_q, wr_d, wi_q, wi_d;
   logic signed [AW-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
   logic signed [N-1:0]  re_q, re_d, im_q, im_d;
   logic signed [N-1:0]  rea_out_q, rea_out_d, ima_out_q, ima_out_d;
   logic                 cal_en_q, cal_en_d;

   logic signed [N-1:0]  op_a, op_b;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prod_ext;

   // Round half up, arithmetic shift, then reduce to N bits.
   function automatic logic signed [N-1:0] scale(input logic signed [AW-1:0] x);
      logic signed [AW-1:0] r;
      r = (x + RND) >>> FRAC;
`ifdef TWIDDLE_SAT_EN
      if (r > MAX_V) return MAX_V[N-1:0];
      if (r < MIN_V) return MIN_V[N-1:0];
`endif
      return r[N-1:0];
   endfunction

   always_comb begin
      op_a = '0;
      op_b = '0;
      case (state_q)
         M0: begin op_a = reb_q; op_b = wr_q; end
         M1: begin op_a = imb_q; op_b = wi_q; end
         M2: begin op_a = reb_q; op_b = wi_q; end
         M3: begin op_a = imb_q; op_b = wr_q; end
         default: begin op_a = '0; op_b = '0; end
      endcase
   end

   assign prod     = PW'(op_a) * PW'(op_b);
   assign prod_ext = {prod[PW-1], prod};

   always_comb begin
      state_d   = state_q;
      rea_d     = rea_q;
      ima_d     = ima_q;
      reb_d     = reb_q;
      imb_d     = imb_q;
      wr_d      = wr_q;
      wi_d      = wi_q;
      acc_r_d   = acc_r_q;
      acc_i_d   = acc_i_q;
      re_d      = re_q;
      im_d      = im_q;
      rea_out_d = rea_out_q;
      ima_out_d = ima_out_q;
      cal_en_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.mul_en) begin
               rea_d   = bus.Rea;
               ima_d   = bus.Ima;
               reb_d   = bus.Reb;
               imb_d   = bus.Imb;
               wr_d    = bus.Wr;
               wi_d    = bus.Wi;
               state_d = M0;
            end
         end
         M0: begin
            acc_r_d = prod_ext;
            state_d = M1;
         end
         M1: begin
            acc_r_d = acc_r_q - prod_ext;
            state_d = M2;
         end
         M2: begin
            re_d    = scale(acc_r_q);
            acc_i_d = prod_ext;
            state_d = M3;
         end
         M3: begin
            im_d      = scale(acc_i_q + prod_ext);
            rea_out_d = rea_q;
            ima_out_d = ima_q;
            cal_en_d  = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!nRst) begin
         state_q   <= IDLE;
         rea_q     <= '0;
         ima_q     <= '0;
         reb_q     <= '0;
         imb_q     <= '0;
         wr_q      <= '0;
         wi_q      <= '0;
         acc_r_q   <= '0;
         acc_i_q   <= '0;
         re_q      <= '0;
         im_q      <= '0;
         rea_out_q <= '0;
         ima_out_q <= '0;
         cal_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rea_q     <= rea_d;
         ima_q     <= ima_d;
         reb_q     <= reb_d;
         imb_q     <= imb_d;
         wr_q      <= wr_d;
         wi_q      <= wi_d;
         acc_r_q   <= acc_r_d;
         acc_i_q   <= acc_i_d;
         re_q      <= re_d;
         im_q      <= im_d;
         rea_out_q <= rea_out_d;
         ima_out_q <= ima_out_d;
         cal_en_q  <= cal_en_d;
      end
   end

   assign bus.RE     = re_q;
   assign bus.IM     = im_q;
   assign bus.Rea_q  = rea_out_q;
   assign bus.Ima_q  = ima_out_q;
   assign bus.cal_en = cal_en_q;
   assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_twiddle_mul.sv
// Directed bench for twiddle_mul: timed checks plus a scoreboard compared on every cal_en.
module tb_twiddle_mul;

   localparam int N    = 8;
   localparam int FRAC = 7;

   logic Clock;
   logic nRst;

   twiddle_mul_if #(.N(N)) bus ();

   twiddle_mul #(.N(N), .FRAC(FRAC)) dut (
      .Clock (Clock),
      .nRst  (nRst),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [7:0] re;
      logic [7:0] im;
      logic [7:0] rea;
      logic [7:0] ima;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   function automatic logic [7:0] exp_scale(input int x);
      int r;
      r = (x + (1 << (FRAC - 1))) >>> FRAC;
`ifdef TWIDDLE_SAT_EN
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
`endif
      return r[7:0];
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic start(input int reb, input int imb, input int wr, input int wi,
                        input int rea, input int ima, input bit expect_result);
      exp_t e;
      int   rea_v, ima_v;
      bus.Reb    = 8'(reb);
      bus.Imb    = 8'(imb);
      bus.Wr     = 8'(wr);
      bus.Wi     = 8'(wi);
      bus.Rea    = 8'(rea);
      bus.Ima    = 8'(ima);
      bus.mul_en = 1'b1;
      if (expect_result) begin
         rea_v = rea;
         ima_v = ima;
         e.re  = exp_scale(reb * wr - imb * wi);
         e.im  = exp_scale(reb * wi + imb * wr);
         e.rea = rea_v[7:0];
         e.ima = ima_v[7:0];
         sb_q.push_back(e);
      end
   endtask

   always @(negedge Clock) begin
      if (nRst && bus.cal_en) begin
         n_cmp++;
         assert (sb_q.size() != 0) else begin
            n_mis++;
            $error("FAIL cal_en_spurious observed=1 expected=0");
         end
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_re",    bus.RE,    e.re);
            check("sb_im",    bus.IM,    e.im);
            check("sb_rea_q", bus.Rea_q, e.rea);
            check("sb_ima_q", bus.Ima_q, e.ima);
         end
      end
   end

   initial begin
      logic [7:0] ovf_exp;
      nRst       = 1'b0;
      bus.mul_en = 1'b0;
      bus.Rea    = '0;
      bus.Ima    = '0;
      bus.Reb    = '0;
      bus.Imb    = '0;
      bus.Wr     = '0;
      bus.Wi     = '0;

      // reset / idle
      step();
      step();
      nRst = 1'b1;
      step();
      check("rst_re",     bus.RE,     8'h00);
      check("rst_im",     bus.IM,     8'h00);
      check("rst_rea_q",  bus.Rea_q,  8'h00);
      check("rst_ima_q",  bus.Ima_q,  8'h00);
      check("rst_cal_en", bus.cal_en, 8'h00);
      check("rst_busy",   bus.busy,   8'h00);
      step();
      check("idle_cal_en", bus.cal_en, 8'h00);

      // near-unity
      start(64, 0, 127, 0, 5, -3, 1'b1);
      step();                                   // edge k
      bus.mul_en = 1'b0;
      check("nu_busy_k", bus.busy, 8'h01);
      step();
      check("nu_cal_k1", bus.cal_en, 8'h00);
      step();
      check("nu_cal_k2", bus.cal_en, 8'h00);
      step();
      check("nu_re_k3",  bus.RE,     8'd64);
      check("nu_cal_k3", bus.cal_en, 8'h00);
      check("nu_busy_k3", bus.busy,  8'h01);
      step();
      check("nu_im_k4",    bus.IM,     8'h00);
      check("nu_rea_k4",   bus.Rea_q,  8'd5);
      check("nu_ima_k4",   bus.Ima_q,  8'hFD);
      check("nu_cal_k4",   bus.cal_en, 8'h01);
      check("nu_busy_k4",  bus.busy,   8'h00);
      step();
      check("nu_cal_k5", bus.cal_en, 8'h00);

      // W = -j, ignored pulse while busy, back-to-back restart
      start(10, 20, 0, -128, 7, 9, 1'b1);
      step();                                   // edge k
      bus.mul_en = 1'b0;
      step();                                   // k+1
      start(100, 100, 100, 100, 1, 1, 1'b0);
      step();                                   // k+2, must be ignored
      bus.mul_en = 1'b0;
      check("mj_busy_k2", bus.busy, 8'h01);
      step();                                   // k+3
      check("mj_re_k3", bus.RE, 8'd20);
      step();                                   // k+4
      check("mj_im_k4",  bus.IM,     8'hF6);
      check("mj_cal_k4", bus.cal_en, 8'h01);
      start(1, 0, 64, 0, 2, 3, 1'b1);           // rounding up: RE = 1
      step();                                   // k+5
      bus.mul_en = 1'b0;
      check("mj_busy_k5", bus.busy, 8'h01);
      for (int i = 5; i <= 7; i++) begin
         check($sformatf("mj_re_hold_k%0d", i),  bus.RE,    8'd20);
         check($sformatf("mj_im_hold_k%0d", i),  bus.IM,    8'hF6);
         check($sformatf("mj_rea_hold_k%0d", i), bus.Rea_q, 8'd7);
         step();
      end
      check("mj_im_hold_k8",  bus.IM,    8'hF6);
      check("mj_ima_hold_k8", bus.Ima_q, 8'd9);
      check("rnd_up_re_k8",   bus.RE,    8'd1);
      step();                                   // k+9
      check("rnd_up_im_k9",  bus.IM,     8'h00);
      check("rnd_up_rea_k9", bus.Rea_q,  8'd2);
      check("rnd_up_cal_k9", bus.cal_en, 8'h01);
      step();

      // rounding down: 63/128 + 0.5 < 1
      start(1, 0, 63, 0, 0, 0, 1'b1);
      step();
      bus.mul_en = 1'b0;
      step();
      step();
      step();
      check("rnd_dn_re", bus.RE, 8'h00);
      step();
      step();

      // overflow
`ifdef TWIDDLE_SAT_EN
      ovf_exp = 8'h7F;
`else
      ovf_exp = 8'h80;
`endif
      start(-128, -128, -128, 0, 0, 0, 1'b1);
      step();
      bus.mul_en = 1'b0;
      step();
      step();
      step();
      check("ovf_re", bus.RE, ovf_exp);
      step();
      check("ovf_im", bus.IM, ovf_exp);
      step();

      // reset mid-operation
      start(64, 0, 127, 0, 5, 5, 1'b0);
      step();                                   // edge k
      bus.mul_en = 1'b0;
      step();                                   // k+1
      nRst = 1'b0;
      step();                                   // k+2, reset sampled
      nRst = 1'b1;
      step();                                   // k+3
      check("mr_re",     bus.RE,     8'h00);
      check("mr_im",     bus.IM,     8'h00);
      check("mr_rea_q",  bus.Rea_q,  8'h00);
      check("mr_ima_q",  bus.Ima_q,  8'h00);
      check("mr_cal_en", bus.cal_en, 8'h00);
      check("mr_busy",   bus.busy,   8'h00);
      start(0, 64, 0, 127, 4, 6, 1'b1);
      step();                                   // k+4, fresh start
      bus.mul_en = 1'b0;
      step();
      step();
      step();
      check("mr_fresh_re", bus.RE, 8'hC1);
      step();
      check("mr_fresh_cal", bus.cal_en, 8'h01);
      check("mr_fresh_im",  bus.IM,     8'h00);
      for (int i = 0; i < 8; i++) step();

      check("sb_drained", 8'(sb_q.size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/twiddle_mul.md
# twiddle_mul

Twiddle-factor complex multiplier for one radix-2 butterfly, sitting directly upstream of the butterfly add/sub sequencer. Takes operand b (Reb, Imb) and twiddle W (Wr, Wi), computes b·W with one shared signed n×n multiplier over four cycles, then presents RE/IM plus the delayed a operand (Rea_q, Ima_q). It pulses cal_en to start the add/sub stage.

## Interface
- n, 8: data/twiddle width, two's complement.
- FRAC, n-1: twiddle fraction bits (Wr, Wi in Q1.FRAC); 1 ≤ FRAC ≤ n-1.

- Clock  in  1  rising-edge clock.
- nRst  in  1  synchronous active-low reset, sampled on rising Clock edge.
- mul_en  in  1  start request; sampled only in IDLE.
- Rea, Ima  in  n  butterfly a operand, captured with mul_en.
- Reb, Imb  in  n  butterfly b operand, captured with mul_en.
- Wr, Wi  in  n  twiddle, captured with mul_en.
- RE, IM  out  n  scaled b·W result.
- Rea_q, Ima_q  out  n  captured a operand, aligned with IM.
- cal_en  out  1  one-cycle pulse: RE, IM, Rea_q, Ima_q valid.
- busy  out  1  combinational, high when state ≠ IDLE.

## Operation
- States: IDLE, M0, M1, M2, M3. Accumulators acc_r, acc_i are signed 2n+1 bits; products are signed 2n bits, sign-extended.
- IDLE: cal_en <= 0. If mul_en: capture Rea, Ima, Reb, Imb, Wr, Wi into internal registers; go to M0. Else stay.
- M0: acc_r <= Reb·Wr; go to M1.
- M1: acc_r <= acc_r − Imb·Wi; go to M2.
- M2: RE <= scale(acc_r); acc_i <= Reb·Wi; go to M3.
- M3: IM <= scale(acc_i + Imb·Wr); Rea_q <= Rea; Ima_q <= Ima; cal_en <= 1; go to IDLE.
- The single multiplier's operand mux is selected by state only. There is exactly one multiply per cycle.
- scale(x): add 2^(FRAC−1), arithmetic shift right by FRAC, reduce to n bits (see Configuration). Rounding is round-half-up: +0.5 rounds toward +∞.
- mul_en while busy is ignored. Operands are not re-captured.
- Outputs hold their values until next overwritten. Undefined/default state goes to IDLE.

## Timing
- Reset (nRst low at an edge): state IDLE; RE, IM, Rea_q, Ima_q, cal_en, all internal registers = 0; busy = 0. Reset mid-operation aborts; no cal_en is issued.
- mul_en sampled high at edge k: M0 at k+1, M1 at k+2, RE updated at k+3, IM/Rea_q/Ima_q updated at k+4. cal_en is high for the cycle between edges k+4 and k+5.
- busy is high from after edge k until after edge k+4.
- A new mul_en is accepted at k+5 at the earliest, coincident with the cycle cal_en is high. Peak throughput is one result per 5 cycles, matching the downstream sequencer.
- Hold guarantee for downstream:
  - RE is stable for edges k+5…k+7.
  - IM, Rea_q and Ima_q are stable for edges k+5…k+8, even with back-to-back starts.
  - This holds because the next RE write is at k+8 at the earliest and the next IM write is at k+9 at the earliest.

## Configuration
- TWIDDLE_SAT_EN defined: the n-bit reduction in scale() saturates to [−2^(n−1), 2^(n−1)−1].
- TWIDDLE_SAT_EN undefined: scale() keeps the low n bits (wrap-around). There is no other behavioural difference.

## Test plan
(n=8, FRAC=7)
- Reset/idle: nRst=0 for 2 edges, then release with mul_en=0 → all outputs 0, busy=0, cal_en never asserts.
- Near-unity: Reb=64, Imb=0, Wr=127, Wi=0, Rea=5, Ima=−3; mul_en at edge k → RE=64 at k+3; IM=0, Rea_q=5, Ima_q=−3 at k+4; cal_en=1 only between k+4 and k+5.
- W=−j with back-to-back start:
  - Reb=10, Imb=20, Wr=0, Wi=−128 → RE=20, IM=−10.
  - Second start at k+5 → RE unchanged through k+7, IM unchanged through k+8.
  - mul_en pulsed at k+2 is ignored.
- Rounding: Reb=1, Wr=64, others 0 → RE=1. Reb=1, Wr=63 → RE=0.
- Overflow: Reb=Imb=Wr=−128, Wi=0 → RE=IM=127 with TWIDDLE_SAT_EN; RE=IM=−128 without.
- Reset mid-op: start at k, nRst=0 at k+2 → at k+3 state IDLE, all outputs 0, no cal_en; a fresh start at k+4 completes normally.
